long_mul_seq: RTL
=================

Name: long_mul_seq

Overview:
Iterative shift-add sequencer for the long-multiply path (UMULL/SMULL/UMLAL/SMLAL) of the multicycle core. The main control FSM pulses start from its execute state and stalls on busy. It writes result_lo and result_hi to the register file in two consecutive write-back states once done pulses. The block owns the operand, accumulator and counter registers and runs one multiplier bit per cycle.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned
accumulate  input  1  1 = add acc_in to the product
src_a  input  WIDTH  multiplicand
src_b  input  WIDTH  multiplier
acc_in  input  2*WIDTH  accumulate value {hi,lo}
flush  input  1  synchronous abort to IDLE
busy  output  1  high from accepted start through the DONE state inclusive
done  output  1  single-cycle pulse; result valid
result_lo  output  WIDTH  low word of the result
result_hi  output  WIDTH  high word of the result

Behaviour:
- Reset: state IDLE; busy=0; done=0; result_lo=0; result_hi=0; all internal registers cleared.
- States: IDLE -> LOAD -> ITER -> SIGN -> DONE -> IDLE.
- IDLE: start=1 captures src_a, src_b, acc_in, signed_op and accumulate, then goes to LOAD. start is ignored in every other state; there is no queueing.
- LOAD:
  - Signed mode: convert the operands to magnitudes and record neg = sign(a) XOR sign(b).
  - Unsigned mode: neg = 0.
  - Clear the 2*WIDTH product register and load counter = WIDTH.
- ITER, one bit per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper WIDTH+1 bits of the product.
  - Then shift the {carry,product} register right by 1 and shift the multiplier right by 1.
  - Decrement the counter. When the counter reaches 1 in this cycle, go to SIGN. ITER lasts exactly WIDTH cycles.
- SIGN:
  - If neg, the product is replaced by its two's complement (2*WIDTH bits).
  - If accumulate, the captured acc_in is added.
  - The sum wraps modulo 2^(2*WIDTH); no overflow flag is produced.
- DONE:
  - result_lo/result_hi are registered from the product on entry to DONE.
  - done=1 for exactly this one cycle, then return to IDLE.
- Latency: start sampled high at edge N gives done high during the cycle after edge N+WIDTH+2, i.e. WIDTH+3 cycles of busy (35 for WIDTH=32). Back-to-back: start may be reasserted the cycle after done.
- Results hold their value until the next DONE. flush and reset do not change them, except that reset zeroes them.
- flush (any state except IDLE): go to IDLE next edge, busy=0, no done pulse, results unchanged. flush has priority over start in IDLE, so start is not accepted.
- Asynchronous reset mid-operation: immediate return to the reset values; no done.
- The most negative operand in signed mode: magnitude 2^(WIDTH-1) must be represented without truncation. Use WIDTH-bit unsigned magnitude plus the neg flag.
- Operand inputs may change freely after the start cycle; only captured values are used.

Test Plan:
1. Unsigned 0xFFFFFFFF * 0xFFFFFFFF, accumulate=0 -> done at cycle 35 after start, result_hi=0xFFFFFFFE, result_lo=0x00000001, busy high exactly 35 cycles.
2. Signed 0xFFFFFFFD (-3) * 0x00000005 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1; the same operands unsigned -> result_hi=0x00000004, result_lo=0xFFFFFFF1.
3. Signed 0x80000000 * 0x80000000 -> result_hi=0x40000000, result_lo=0x00000000. Signed 0x80000000 * 0x00000001 -> result_hi=0xFFFFFFFF, result_lo=0x80000000.
4. Accumulate: 2 * 3 + acc_in=0x00000001_FFFFFFFF -> result 0x00000002_00000005. Accumulate wrap: 1 * 1 + 0xFFFFFFFF_FFFFFFFF -> result 0x00000000_00000000.
5. Protocol checks:
   - start held high through a whole operation -> exactly one done; a second operation is accepted only after done.
   - start asserted the cycle after done -> the new operation completes 35 cycles later.
6. flush at ITER cycle 10 -> busy drops next cycle, no done, results still hold the previous values. Asynchronous reset low mid-ITER -> busy=0, done=0, results=0 immediately.

Source files
------------

// File: rtl/long_mul_seq.sv
// Sequential shift-add long multiplier (UMULL/SMULL/UMLAL/SMLAL), one multiplier bit per cycle.
// Latency: start accepted at edge N -> done pulses in the cycle after edge N+WIDTH+2 (WIDTH+3 busy cycles).
// Backpressure: none queued; start is only sampled while idle, caller stalls on busy; flush aborts.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       request a multiply (sampled only when idle, and not while flush is high)
//   signed_op   1 = two's-complement operands, 0 = unsigned
//   accumulate  1 = add acc_in to the product
//   src_a       multiplicand
//   src_b       multiplier
//   acc_in      accumulate value {hi,lo}
//   flush       synchronous abort back to idle; no done, results untouched
//   busy        high from the accepted start through the done cycle inclusive
//   done        single-cycle pulse; result_lo/result_hi valid
//   result_lo   low word of the last completed result
//   result_hi   high word of the last completed result
module long_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic               accumulate,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured request and working registers.
    logic [WIDTH-1:0]   mcand;     // raw src_a after capture, magnitude after LOAD
    logic [WIDTH-1:0]   mplier;    // raw src_b after capture, magnitude after LOAD, shifts right in ITER
    logic [2*WIDTH-1:0] acc_q;
    logic               sgn_q;
    logic               acc_en_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;

    // Datapath combinational terms.
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] iter_prod;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] fin_prod;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               accept;

    // flush wins over start while idle.
    assign accept = (state == S_IDLE) && start && !flush;

    //------------------------------------------------------------------
    // Control FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                // Counter was loaded with WIDTH, so the cycle that sees 1 is the last bit.
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_SIGN;
                end
            end
            S_SIGN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    //------------------------------------------------------------------
    // Datapath
    //------------------------------------------------------------------
    always_comb begin
        // Magnitudes stay WIDTH-bit unsigned, so the most negative value
        // negates to exactly 2^(WIDTH-1) without loss.
        mag_a = mcand;
        mag_b = mplier;
        if (sgn_q && mcand[WIDTH-1]) begin
            mag_a = (~mcand) + WIDTH'(1);
        end
        if (sgn_q && mplier[WIDTH-1]) begin
            mag_b = (~mplier) + WIDTH'(1);
        end

        // Add the multiplicand into the upper half with a carry bit, then
        // shift the whole {carry,product} right by one.
        upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (mplier[0]) begin
            upper_sum = upper_sum + {1'b0, mcand};
        end
        iter_prod = {upper_sum, prod[WIDTH-1:1]};

        prod_signed = prod;
        if (neg_q) begin
            prod_signed = (~prod) + (2*WIDTH)'(1);
        end
        // Accumulation wraps modulo 2^(2*WIDTH).
        fin_prod = prod_signed;
        if (acc_en_q) begin
            fin_prod = prod_signed + acc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand     <= '0;
            mplier    <= '0;
            acc_q     <= '0;
            sgn_q     <= 1'b0;
            acc_en_q  <= 1'b0;
            neg_q     <= 1'b0;
            prod      <= '0;
            cnt       <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand    <= src_a;
                        mplier   <= src_b;
                        acc_q    <= acc_in;
                        sgn_q    <= signed_op;
                        acc_en_q <= accumulate;
                    end
                end
                S_LOAD: begin
                    mcand  <= mag_a;
                    mplier <= mag_b;
                    neg_q  <= sgn_q & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
                    prod   <= '0;
                    cnt    <= CNT_W'(WIDTH);
                end
                S_ITER: begin
                    prod   <= iter_prod;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                S_SIGN: begin
                    prod <= fin_prod;
                    // Results only change when DONE is actually entered.
                    if (!flush) begin
                        result_lo <= fin_prod[WIDTH-1:0];
                        result_hi <= fin_prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
